// File: rtl/btn_acond_pulsos.sv
// Push-button conditioner: per-lane 2-FF synchroniser, counter debounce,
// one-cycle press pulse and optional auto-repeat while the button is held.
module btn_acond_pulsos #(
    parameter int N_BTN     = 4,
    parameter int DEB_CYC   = 500000,
    parameter int REP_DELAY = 25000000,
    parameter int REP_RATE  = 5000000,
    parameter int REP_EN    = 1,
    parameter int CNT_W     = 25
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             en_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] pulse_o
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} rep_state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REP_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [N_BTN-1:0] s1, s2;

    // NOTE: sequential state uses non-blocking assignments so s2 takes the
    // previous s1, not the value written in the same edge.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        logic             level_q, level_nxt;
        logic             pulse_q, pulse_nxt;
        logic [CNT_W-1:0] dcnt, dcnt_nxt;
        logic [CNT_W-1:0] rcnt, rcnt_nxt;
        rep_state_t       state, state_nxt;
        logic             rise, fall;

        // NOTE: every combinational output gets a default first, so no
        // path through the block leaves it unassigned and infers a latch.
        always_comb begin
            dcnt_nxt  = '0;
            level_nxt = level_q;
            if (s2[g] != level_q) begin
                if (dcnt == DEB_LAST)
                    level_nxt = s2[g];
                else if (dcnt != CNT_MAX)
                    dcnt_nxt = dcnt + CNT_ONE;
                else
                    dcnt_nxt = dcnt;
            end
        end

        // Edges are taken from the next level so the press pulse lands on
        // the same clock edge that level_o rises.
        assign rise = level_nxt & ~level_q;
        assign fall = ~level_nxt & level_q;

        always_comb begin
            state_nxt = state;
            rcnt_nxt  = rcnt;
            pulse_nxt = 1'b0;
            if (!en_i || fall) begin
                state_nxt = IDLE;
                rcnt_nxt  = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            pulse_nxt = 1'b1;
                            rcnt_nxt  = '0;
                            state_nxt = (REP_EN != 0) ? DELAY : HOLD;
                        end
                    end
                    DELAY: begin
                        if (rcnt == DELAY_LAST) begin
                            pulse_nxt = 1'b1;
                            rcnt_nxt  = '0;
                            state_nxt = REPEAT;
                        end else if (rcnt != CNT_MAX) begin
                            rcnt_nxt = rcnt + CNT_ONE;
                        end
                    end
                    REPEAT: begin
                        if (rcnt == RATE_LAST) begin
                            pulse_nxt = 1'b1;
                            rcnt_nxt  = '0;
                        end else if (rcnt != CNT_MAX) begin
                            rcnt_nxt = rcnt + CNT_ONE;
                        end
                    end
                    HOLD:    state_nxt = HOLD;
                    default: state_nxt = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge reset) begin
            if (reset) begin
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                dcnt    <= '0;
                rcnt    <= '0;
                state   <= IDLE;
            end else begin
                level_q <= level_nxt;
                pulse_q <= pulse_nxt;
                dcnt    <= dcnt_nxt;
                rcnt    <= rcnt_nxt;
                state   <= state_nxt;
            end
        end

        assign level_o[g] = level_q;
        assign pulse_o[g] = pulse_q;
    end

endmodule
